// File: rtl/sparse_idx_gen.sv
// Builds the support of a weight-W sparse polynomial: pulls RNG words, splits them
// into lane candidates, and stores each in-range, previously unseen index in the RAM.
module sparse_idx_gen #(
    parameter int R         = 11027,
    parameter int W         = 67,
    parameter int RNG_DAT_W = 64,
    parameter int LANES     = 2,
    parameter int IDX_W     = 14,
    parameter int ADDR_W    = 7
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    output logic [ADDR_W:0]      count,
    output logic                 rng_start,
    output logic                 fifo_rng_rd,
    input  logic                 fifo_rng_empty,
    input  logic [RNG_DAT_W-1:0] fifo_rng_din,
    output logic [ADDR_W-1:0]    h_addra,
    output logic                 h_wea,
    output logic [IDX_W-1:0]     h_douta,
    input  logic [IDX_W-1:0]     h_dina,
    output logic [ADDR_W-1:0]    h_addrb,
    input  logic [IDX_W-1:0]     h_dinb
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_W_V  = CNT_W'(W);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [LANE_W-1:0] LANE_ONE = 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
    localparam logic [31:0]       R_U      = 32'(R);

    typedef enum logic [2:0] {IDLE, FETCH, SEL, SCAN, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [RNG_DAT_W-1:0]   word_q, word_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]      j_q, j_d;
    logic                   issue_q, issue_d;
    logic                   rdv_q, rdv_d;
    logic [CNT_W-1:0]       rdBase_q, rdBase_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   rng_q, rng_d;
    logic                   rd_q, rd_d;
    logic                   wea_q, wea_d;
    logic [ADDR_W-1:0]      addra_q, addra_d;
    logic [ADDR_W-1:0]      addrb_q, addrb_d;
    logic [IDX_W-1:0]       douta_q, douta_d;

    logic [IDX_W-1:0]       laneField [LANES];
    logic [IDX_W-1:0]       cand;
    logic                   candOk;
    logic                   lastLane;
    logic [LANE_W-1:0]      advLane;
    state_t                 advState;
    logic [CNT_W-1:0]       pairBase;
    logic                   hitA, hitB;
    logic                   unusedWord;

    // Only the low IDX_W bits of each 16-bit lane carry an index; the rest is folded away.
    assign unusedWord = ^{word_q, fifo_rng_din};

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            laneField[k] = word_q[16*k +: IDX_W];
        end
    end

    assign cand     = laneField[lane_q];
    assign candOk   = 32'(cand) < R_U;
    assign lastLane = (lane_q == LANE_MAX);
    assign advLane  = lastLane ? lane_q : lane_q + LANE_ONE;
    assign advState = lastLane ? FETCH : SEL;
    assign pairBase = {j_q, 1'b0};

    // Read data lags the issued pair by one cycle; entries at or beyond count are stale.
    assign hitA = rdv_q && (rdBase_q < count_q) && (h_dina == cand);
    assign hitB = rdv_q && ((rdBase_q + CNT_ONE) < count_q) && (h_dinb == cand);

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        lane_d   = lane_q;
        count_d  = count_q;
        j_d      = j_q;
        issue_d  = 1'b0;
        rdv_d    = issue_q;
        rdBase_d = {1'b0, addra_q};
        done_d   = 1'b0;
        busy_d   = busy_q;
        rng_d    = rng_q;
        rd_d     = 1'b0;
        wea_d    = 1'b0;
        addra_d  = addra_q;
        addrb_d  = addrb_q;
        douta_d  = douta_q;

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    count_d = '0;
                    busy_d  = 1'b1;
                    rng_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!fifo_rng_empty) begin
                    word_d  = fifo_rng_din;
                    rd_d    = 1'b1;
                    lane_d  = '0;
                    state_d = SEL;
                end
            end
            SEL: begin
                if (!candOk) begin
                    lane_d  = advLane;
                    state_d = advState;
                end else if (count_q == '0) begin
                    wea_d   = 1'b1;
                    addra_d = count_q[ADDR_W-1:0];
                    douta_d = cand;
                    state_d = WRITE;
                end else begin
                    addra_d = '0;
                    addrb_d = ADDR_ONE;
                    j_d     = ADDR_ONE;
                    issue_d = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hitA || hitB) begin
                    lane_d  = advLane;
                    state_d = advState;
                end else if (rdv_q && !issue_q) begin
                    wea_d   = 1'b1;
                    addra_d = count_q[ADDR_W-1:0];
                    douta_d = cand;
                    state_d = WRITE;
                end else if (pairBase < count_q) begin
                    addra_d = pairBase[ADDR_W-1:0];
                    addrb_d = {pairBase[ADDR_W-1:1], 1'b1};
                    j_d     = j_q + ADDR_ONE;
                    issue_d = 1'b1;
                end
            end
            WRITE: begin
                count_d = count_q + CNT_ONE;
                if ((count_q + CNT_ONE) == CNT_W_V) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rng_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    lane_d  = advLane;
                    state_d = advState;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            word_q   <= '0;
            lane_q   <= '0;
            count_q  <= '0;
            j_q      <= '0;
            issue_q  <= 1'b0;
            rdv_q    <= 1'b0;
            rdBase_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rng_q    <= 1'b0;
            rd_q     <= 1'b0;
            wea_q    <= 1'b0;
            addra_q  <= '0;
            addrb_q  <= '0;
            douta_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            lane_q   <= lane_d;
            count_q  <= count_d;
            j_q      <= j_d;
            issue_q  <= issue_d;
            rdv_q    <= rdv_d;
            rdBase_q <= rdBase_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rng_q    <= rng_d;
            rd_q     <= rd_d;
            wea_q    <= wea_d;
            addra_q  <= addra_d;
            addrb_q  <= addrb_d;
            douta_q  <= douta_d;
        end
    end

    assign done        = done_q;
    assign busy        = busy_q;
    assign count       = count_q;
    assign rng_start   = rng_q;
    assign fifo_rng_rd = rd_q;
    assign h_wea       = wea_q;
    assign h_addra     = addra_q;
    assign h_addrb     = addrb_q;
    assign h_douta     = douta_q;

endmodule

// File: tb/tb_sparse_idx_gen.sv
// Directed and random bench for sparse_idx_gen: a FIFO and RAM model around the DUT,
// and a scoreboard of expected (address, index) writes built from a set-based model.
module tb_sparse_idx_gen;

    localparam int R          = 11027;
    localparam int W          = 67;
    localparam int RNG_DAT_W  = 64;
    localparam int LANES      = 2;
    localparam int IDX_W      = 14;
    localparam int ADDR_W     = 7;
    localparam int FIFO_DEPTH = 1024;

    logic                 clk = 1'b0;
    logic                 rst_b;
    logic                 start;
    logic                 done;
    logic                 busy;
    logic [ADDR_W:0]      count;
    logic                 rng_start;
    logic                 fifo_rng_rd;
    logic                 fifo_rng_empty;
    logic [RNG_DAT_W-1:0] fifo_rng_din;
    logic [ADDR_W-1:0]    h_addra;
    logic                 h_wea;
    logic [IDX_W-1:0]     h_douta;
    logic [IDX_W-1:0]     h_dina;
    logic [ADDR_W-1:0]    h_addrb;
    logic [IDX_W-1:0]     h_dinb;

    sparse_idx_gen #(
        .R(R), .W(W), .RNG_DAT_W(RNG_DAT_W), .LANES(LANES), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .done(done), .busy(busy), .count(count),
        .rng_start(rng_start), .fifo_rng_rd(fifo_rng_rd), .fifo_rng_empty(fifo_rng_empty),
        .fifo_rng_din(fifo_rng_din), .h_addra(h_addra), .h_wea(h_wea), .h_douta(h_douta),
        .h_dina(h_dina), .h_addrb(h_addrb), .h_dinb(h_dinb)
    );

    always #5 clk = ~clk;

    // First-word-fall-through FIFO: the bench appends, the DUT's pop strobe advances.
    logic [RNG_DAT_W-1:0] fifoMem [FIFO_DEPTH];
    int wrPtr = 0;
    int rdPtr = 0;
    assign fifo_rng_empty = (rdPtr == wrPtr);
    assign fifo_rng_din   = fifoMem[rdPtr % FIFO_DEPTH];

    always @(posedge clk) begin
        if (fifo_rng_rd && (rdPtr != wrPtr)) rdPtr <= rdPtr + 1;
    end

    // Dual-port index RAM with one cycle of read latency on both ports.
    logic [IDX_W-1:0] ram [2**ADDR_W];
    always @(posedge clk) begin
        if (h_wea) ram[h_addra] <= h_douta;
        h_dina <= ram[h_addra];
        h_dinb <= ram[h_addrb];
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [IDX_W-1:0]  data;
    } exp_t;

    exp_t expQ [$];
    logic seen [1 << IDX_W];
    int   modelCount;
    int   compared   = 0;
    int   mismatched = 0;
    int   popsSeen   = 0;
    int   donesSeen  = 0;
    int   runPops, runDones, runWr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, sampled on the falling edge; every DUT write, pop and done is scored here.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (h_wea === 1'b1) begin
            checkOutput("writeExpected", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("writeAddr", 32'(h_addra), 32'(e.addr));
                checkOutput("writeData", 32'(h_douta), 32'(e.data));
            end
        end
        if (fifo_rng_rd === 1'b1) begin
            popsSeen++;
            checkOutput("popWhileEmpty", 32'(fifo_rng_empty), 0);
        end
        if (done === 1'b1) begin
            donesSeen++;
            checkOutput("busyAtDone", 32'(busy), 0);
            checkOutput("rngAtDone", 32'(rng_start), 0);
            checkOutput("countAtDone", 32'(count), W);
        end
    endtask

    task automatic applyStimulus(input logic [RNG_DAT_W-1:0] w);
        logic [IDX_W-1:0] c;
        fifoMem[wrPtr % FIFO_DEPTH] = w;
        wrPtr++;
        for (int k = 0; k < LANES; k++) begin
            c = w[16*k +: IDX_W];
            if (modelCount < W && 32'(c) < R && !seen[c]) begin
                seen[c] = 1'b1;
                expQ.push_back('{addr: ADDR_W'(modelCount), data: c});
                modelCount++;
            end
        end
    endtask

    task automatic beginRun();
        for (int i = 0; i < (1 << IDX_W); i++) seen[i] = 1'b0;
        modelCount = 0;
        expQ.delete();
        runPops  = popsSeen;
        runDones = donesSeen;
        runWr    = wrPtr;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDrained(input string tag, input int budget);
        int n = 0;
        while ((expQ.size() > 0 || rdPtr != wrPtr) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(n < budget), 1);
        repeat (4) tick();
    endtask

    // Tops the run up with random words until the model reaches W, then checks the result.
    task automatic finishRun(input string tag);
        logic [RNG_DAT_W-1:0] w;
        int words = 0;
        int n = 0;
        int dup = 0;
        int outRange = 0;
        while (modelCount < W && words < 500) begin
            w = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) w[31:16] = w[15:0];
            applyStimulus(w);
            words++;
        end
        checkOutput({tag, "WordsEnough"}, modelCount, W);
        while (donesSeen == runDones && n < 20000) begin
            tick();
            n++;
        end
        checkOutput({tag, "DoneTimeout"}, 32'(n < 20000), 1);
        repeat (5) tick();
        checkOutput({tag, "DoneOnce"}, donesSeen - runDones, 1);
        checkOutput({tag, "QueueEmpty"}, expQ.size(), 0);
        checkOutput({tag, "FinalCount"}, 32'(count), W);
        checkOutput({tag, "FinalBusy"}, 32'(busy), 0);
        checkOutput({tag, "PopCount"}, popsSeen - runPops, wrPtr - runWr);
        for (int i = 0; i < W; i++) begin
            if (32'(ram[i]) >= R) outRange++;
            for (int k = 0; k < i; k++) if (ram[i] == ram[k]) dup++;
        end
        checkOutput({tag, "RamInRange"}, outRange, 0);
        checkOutput({tag, "RamDistinct"}, dup, 0);
    endtask

    initial begin
        int n;
        int rdHigh;
        rst_b = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstCount", 32'(count), 0);
        checkOutput("rstRng", 32'(rng_start), 0);
        checkOutput("rstRd", 32'(fifo_rng_rd), 0);
        checkOutput("rstWea", 32'(h_wea), 0);
        rst_b = 1'b1;
        repeat (2) tick();

        $display("[TB] run 1: directed lanes, stall, start while busy");
        beginRun();
        pulseStart();
        checkOutput("startBusy", 32'(busy), 1);
        checkOutput("startRng", 32'(rng_start), 1);
        checkOutput("startCount", 32'(count), 0);

        applyStimulus({32'hDEAD_BEEF, 16'd9, 16'd5});
        applyStimulus({32'h1234_5678, 16'd7, 16'd100});
        waitDrained("basicDrain", 400);
        checkOutput("basicCount", 32'(count), 4);
        checkOutput("basicPops", popsSeen - runPops, 2);

        applyStimulus({32'h0, 16'd16383, 16'd11027});
        applyStimulus({32'h0, 16'd11026, 16'd0});
        waitDrained("rangeDrain", 400);
        checkOutput("rangeCount", 32'(count), 6);
        checkOutput("rangePops", popsSeen - runPops, 4);

        applyStimulus({32'h0, 16'd42, 16'd42});
        applyStimulus({32'h0, 16'd43, 16'd42});
        waitDrained("dupDrain", 400);
        checkOutput("dupCount", 32'(count), 8);
        checkOutput("dupPops", popsSeen - runPops, 6);

        rdHigh = 0;
        repeat (20) begin
            tick();
            if (fifo_rng_rd) rdHigh++;
        end
        checkOutput("stallNoPop", rdHigh, 0);
        checkOutput("stallBusy", 32'(busy), 1);

        pulseStart();
        tick();
        checkOutput("startIgnoredCount", 32'(count), 8);
        checkOutput("startIgnoredBusy", 32'(busy), 1);
        finishRun("run1");

        $display("[TB] run 2: asynchronous reset during a scan");
        beginRun();
        pulseStart();
        applyStimulus({32'h0, 16'd500, 16'd500});
        n = 0;
        while (expQ.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (h_addrb !== 7'd1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("reachScan", 32'(h_addrb), 1);
        rst_b = 1'b0;
        #1;
        checkOutput("asyncDone", 32'(done), 0);
        checkOutput("asyncBusy", 32'(busy), 0);
        checkOutput("asyncCount", 32'(count), 0);
        checkOutput("asyncRng", 32'(rng_start), 0);
        checkOutput("asyncRd", 32'(fifo_rng_rd), 0);
        checkOutput("asyncWea", 32'(h_wea), 0);
        checkOutput("asyncAddra", 32'(h_addra), 0);
        checkOutput("asyncAddrb", 32'(h_addrb), 0);
        checkOutput("asyncDouta", 32'(h_douta), 0);
        expQ.delete();
        repeat (2) tick();
        rst_b = 1'b1;
        tick();

        $display("[TB] run 3: random run after reset");
        beginRun();
        pulseStart();
        checkOutput("run3Busy", 32'(busy), 1);
        finishRun("run3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
